// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the divider sequencer: state encoding, requester id
// and timing constants.
package div_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } div_state_e;

   localparam int ID_W               = 1;
   localparam int TIMEOUT_CYCLES_DEF = 40;
   localparam int DIV_LATENCY        = 33;

   typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/div_arbiter_if.sv
// Requester-side handshake bundle for the two divider clients.
interface div_arbiter_if;
   logic        req0_valid;
   logic        req1_valid;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic        req0_ready;
   logic        req1_ready;
   logic        resp0_valid;
   logic        resp1_valid;
   logic [31:0] resp0_result;
   logic [31:0] resp1_result;
   logic        resp0_exception;
   logic        resp1_exception;

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      input  req0_ready, req1_ready, resp0_valid, resp1_valid,
      input  resp0_result, resp1_result, resp0_exception, resp1_exception
   );

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
      output req0_ready, req1_ready, resp0_valid, resp1_valid,
      output resp0_result, resp1_result, resp0_exception, resp1_exception
   );
endinterface

// File: rtl/div_arbiter_rr.sv
// Two-input round-robin picker; on a tie the requester not granted last wins.
module rr_arbiter_2
   import div_ctrl_pkg::*;
(
   input  logic [1:0] valid,
   input  req_id_t    last_grant,
   output logic [1:0] grant,
   output req_id_t    grant_id
);

   always_comb begin
      grant_id = '0;
      case (valid)
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = '0;
      endcase
      grant = '0;
      if (valid != 2'b00) grant = grant_id ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/div_arbiter.sv
// Sequencer for the shared iterative divider: arbitrates two requesters,
// restarts the divider, waits for its ready flag with a timeout guard.
//
// state | meaning
// IDLE  | waiting for a request; arbitrate and accept
// START | one-cycle divider restart, timer cleared
// RUN   | divider counting; wait for ready or timeout
// DONE  | one-cycle response pulse to the granted requester
module div_arbiter
   import div_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        rst,
   div_arbiter_if.slave req_if,
   output logic [31:0] div_operandA,
   output logic [31:0] div_operandB,
   output logic        div_rst,
   input  logic [31:0] div_result,
   input  logic        div_resultRDY,
   input  logic        div_exception,
   output logic        busy
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   div_state_e         state_q, state_d;
   req_id_t            last_grant_q, last_grant_d;
   req_id_t            grant_id_q, grant_id_d;
   logic [31:0]        a_q, a_d;
   logic [31:0]        b_q, b_d;
   logic [31:0]        result_q, result_d;
   logic               exc_q, exc_d;
   logic [TIMER_W-1:0] timer_q, timer_d;

   logic [1:0] arb_grant;
   req_id_t    arb_id;
   logic       accept;

   rr_arbiter_2 u_rr (
      .valid      ({req_if.req1_valid, req_if.req0_valid}),
      .last_grant (last_grant_q),
      .grant      (arb_grant),
      .grant_id   (arb_id)
   );

   // Hold off the accept pulse while reset is asserted: the edge discards it anyway.
   assign accept = (state_q == ST_IDLE) && (arb_grant != 2'b00) && rst;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      exc_d        = exc_q;
      timer_d      = timer_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               grant_id_d = arb_id;
               a_d        = arb_id[0] ? req_if.req1_a : req_if.req0_a;
               b_d        = arb_id[0] ? req_if.req1_b : req_if.req0_b;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            timer_d = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (div_resultRDY) begin
               result_d = div_result;
               exc_d    = div_exception;
               state_d  = ST_DONE;
            end else if (timer_q == TIMER_LAST) begin
               result_d = '0;
               exc_d    = 1'b1;
               state_d  = ST_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_DONE: begin
            last_grant_d = grant_id_q;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         grant_id_q   <= '0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         exc_q        <= 1'b0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
         exc_q        <= exc_d;
         timer_q      <= timer_d;
      end
   end

   assign req_if.req0_ready      = accept && arb_grant[0];
   assign req_if.req1_ready      = accept && arb_grant[1];
   assign req_if.resp0_valid     = rst && (state_q == ST_DONE) && (grant_id_q == 1'b0);
   assign req_if.resp1_valid     = rst && (state_q == ST_DONE) && (grant_id_q == 1'b1);
   assign req_if.resp0_result    = result_q;
   assign req_if.resp1_result    = result_q;
   assign req_if.resp0_exception = exc_q;
   assign req_if.resp1_exception = exc_q;

   assign div_operandA = a_q;
   assign div_operandB = b_q;
   assign div_rst      = ~rst | (state_q == ST_START);
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter with a behavioural 33-cycle divider model.
module tb_div_arbiter;
   import div_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] div_operandA, div_operandB, div_result;
   logic        div_rst, div_resultRDY, div_exception, busy;
   logic        stuck = 1'b0;
   logic [5:0]  dcnt;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          lat;
   } exp_t;

   exp_t exp_r0[$];
   exp_t exp_r1[$];
   int   exp_acc[$];
   int   acc_cyc[2];

   div_arbiter_if rif ();

   div_arbiter #(.TIMEOUT_CYCLES(40)) dut (
      .clk           (clk),
      .rst           (rst),
      .req_if        (rif.slave),
      .div_operandA  (div_operandA),
      .div_operandB  (div_operandB),
      .div_rst       (div_rst),
      .div_result    (div_result),
      .div_resultRDY (div_resultRDY),
      .div_exception (div_exception),
      .busy          (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Divider model: ready at count 32 after restart, immediately on zero divisor.
   always @(posedge clk) begin
      if (div_rst) dcnt <= '0;
      else if (dcnt != 6'd63) dcnt <= dcnt + 1'b1;
   end
   assign div_resultRDY = !stuck && !div_rst && ((div_operandB == 32'd0) || (dcnt == 6'd32));
   assign div_exception = (div_operandB == 32'd0);
   assign div_result    = (div_operandB == 32'd0) ? 32'd0 :
                          32'($signed(div_operandA) / $signed(div_operandB));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endtask

   task automatic exp_resp(input int id, input logic [31:0] res, input logic exc, input int lat);
      exp_t e;
      e.res = res;
      e.exc = exc;
      e.lat = lat;
      if (id == 0) exp_r0.push_back(e);
      else         exp_r1.push_back(e);
   endtask

   task automatic check_resp(input int id, input logic [31:0] res, input logic exc);
      exp_t e;
      if (id == 0 && exp_r0.size() == 0) begin flag("resp0_unexpected"); return; end
      if (id == 1 && exp_r1.size() == 0) begin flag("resp1_unexpected"); return; end
      e = (id == 0) ? exp_r0.pop_front() : exp_r1.pop_front();
      chk($sformatf("resp%0d_result", id), res, e.res);
      chk($sformatf("resp%0d_exception", id), 32'(exc), 32'(e.exc));
      chk($sformatf("resp%0d_latency", id), 32'(cyc - acc_cyc[id]), 32'(e.lat));
   endtask

   // Monitor: accept pulses and response pulses are checked against the queues.
   always @(negedge clk) begin
      if (rst) begin
         if (rif.req0_ready && rif.req1_ready) flag("both_ready");
         else if (rif.req0_ready || rif.req1_ready) begin
            if (exp_acc.size() == 0) flag("accept_unexpected");
            else chk("accept_id", 32'(rif.req1_ready), 32'(exp_acc.pop_front()));
            acc_cyc[rif.req1_ready ? 1 : 0] = cyc;
         end
         if (rif.resp0_valid && rif.resp1_valid) flag("both_resp");
         if (rif.resp0_valid) check_resp(0, rif.resp0_result, rif.resp0_exception);
         if (rif.resp1_valid) check_resp(1, rif.resp1_result, rif.resp1_exception);
      end
   end

   task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b);
      bit done = 0;
      @(posedge clk); #1;
      if (id == 0) begin rif.req0_valid = 1'b1; rif.req0_a = a; rif.req0_b = b; end
      else         begin rif.req1_valid = 1'b1; rif.req1_a = a; rif.req1_b = b; end
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if ((id == 0 && rif.req0_ready) || (id == 1 && rif.req1_ready)) done = 1;
      end
      if (!done) flag($sformatf("req%0d_accept_timeout", id));
      @(posedge clk); #1;
      if (id == 0) rif.req0_valid = 1'b0;
      else         rif.req1_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      bit done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (exp_r0.size() == 0 && exp_r1.size() == 0 && exp_acc.size() == 0) done = 1;
      end
      if (!done) flag({name, "_drain_timeout"});
      @(negedge clk);
      chk({name, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rif.req0_valid = 1'b0; rif.req1_valid = 1'b0;
      rif.req0_a = '0; rif.req0_b = '0; rif.req1_a = '0; rif.req1_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_div_rst", 32'(div_rst), 32'd1);
      chk("rst_operandA", div_operandA, 32'd0);
      chk("rst_operandB", div_operandB, 32'd0);
      chk("rst_resp0_result", rif.resp0_result, 32'd0);
      chk("rst_resp_valid", 32'({rif.resp1_valid, rif.resp0_valid}), 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      // 100/7 from req0
      exp_acc.push_back(0);
      exp_resp(0, 32'd14, 1'b0, 35);
      drive_req(0, 32'd100, 32'd7);
      wait_drain("div_100_7");

      // -100/7 from req1
      exp_acc.push_back(1);
      exp_resp(1, 32'hFFFF_FFF2, 1'b0, 35);
      drive_req(1, 32'hFFFF_FF9C, 32'd7);
      wait_drain("div_m100_7");

      // divide by zero
      exp_acc.push_back(0);
      exp_resp(0, 32'd0, 1'b1, 3);
      drive_req(0, 32'd5, 32'd0);
      wait_drain("div_by_zero");

      // timeout with a dead divider
      stuck = 1'b1;
      exp_acc.push_back(0);
      exp_resp(0, 32'd0, 1'b1, 42);
      drive_req(0, 32'd10, 32'd3);
      wait_drain("timeout");
      stuck = 1'b0;

      // reset during RUN aborts without a response
      exp_acc.push_back(0);
      drive_req(0, 32'd100, 32'd7);
      @(negedge clk);
      chk("start_operandA", div_operandA, 32'd100);
      chk("start_div_rst", 32'(div_rst), 32'd1);
      repeat (10) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_div_rst", 32'(div_rst), 32'd1);
      chk("abort_resp0_valid", 32'(rif.resp0_valid), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (40) @(posedge clk);
      exp_acc.push_back(0);
      exp_resp(0, 32'd10, 1'b0, 35);
      drive_req(0, 32'd50, 32'd5);
      wait_drain("after_abort");

      // simultaneous requests: last grant was req0, so req1 wins this tie
      exp_acc.push_back(1); exp_acc.push_back(0);
      exp_resp(1, 32'hFFFF_FFFD, 1'b0, 35);
      exp_resp(0, 32'd5, 1'b0, 35);
      fork
         drive_req(0, 32'd20, 32'd4);
         drive_req(1, 32'hFFFF_FFF7, 32'd3);
      join
      wait_drain("tie_a");
      chk("tie_a_gap", 32'(acc_cyc[0] - acc_cyc[1]), 32'd36);

      // last grant was req0 again; issue a req1 alone to flip it, then tie -> req0
      exp_acc.push_back(1);
      exp_resp(1, 32'd3, 1'b0, 35);
      drive_req(1, 32'd9, 32'd3);
      wait_drain("flip");
      exp_acc.push_back(0); exp_acc.push_back(1);
      exp_resp(0, 32'hFFFF_FFFD, 1'b0, 35);
      exp_resp(1, 32'd100, 1'b0, 35);
      fork
         drive_req(0, 32'd7, 32'hFFFF_FFFE);
         drive_req(1, 32'd1000, 32'd10);
      join
      wait_drain("tie_b");
      chk("tie_b_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd36);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Sequencer and two-way round-robin arbiter for the shared iterative divider. It accepts signed 32-bit divide requests from two requesters over valid/ready handshakes and latches the operands. It restarts the divider, waits for its ready flag (with a timeout guard), then returns the quotient and exception flag to the granted requester as a one-cycle response pulse. It sits between the CPU execute stage and the game-logic coprocessor on one side and the single divider instance on the other.

## Interface
- TIMEOUT_CYCLES, 40, max RUN cycles before forced exception completion; must exceed divider latency (33)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  request pending; held with operands until accepted
- req0_a, req0_b / req1_a, req1_b  in  32  dividend, divisor (two's complement)
- req0_ready / req1_ready  out  1  one-cycle accept pulse
- resp0_valid / resp1_valid  out  1  one-cycle result pulse, no backpressure
- resp0_result / resp1_result  out  32  quotient, valid with resp*_valid
- resp0_exception / resp1_exception  out  1  divide-by-zero or timeout
- div_operandA, div_operandB  out  32  operands to divider, from latched registers
- div_rst  out  1  active-high restart to divider
- div_result  in  32  divider quotient
- div_resultRDY  in  1  divider done
- div_exception  in  1  divider zero-divisor flag
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE: if any valid, grant via round-robin. Both valid: grant the requester not granted last. Latch a/b and grant id, pulse that reqN_ready this cycle, go START.
- START: div_rst=1 for exactly one cycle, clear timer, go RUN. div_resultRDY is ignored in START (stale count).
- RUN: div_rst=0, timer increments each cycle.
  - div_resultRDY=1: capture div_result/div_exception, go DONE.
  - timer == TIMEOUT_CYCLES-1 without ready: capture result 0, exception 1, go DONE.
- DONE: pulse respN_valid of the granted requester with captured values, update last_grant, go IDLE. Requests are accepted only in IDLE; a valid asserted during DONE is accepted the following cycle.
- div_operandA/B hold latched values from START until the next accept; they are never driven directly from request ports.
- resp*_result/exception hold their last value between pulses; only the pulse qualifies them.
- Sign handling and zero-divisor detection stay in the divider; the controller does not modify data.

## Timing
- Reset (rst=0 at clock edge) forces:
  - state IDLE, last_grant=1, so req0 wins the first tie
  - all ready/valid/exception outputs 0, results 0, operands 0, busy 0
  - div_rst=1: div_rst = ~rst OR (state==START)
- Reset mid-operation aborts the request with no response; the requester reissues.
- Accept at cycle T: START T+1, RUN from T+2.
  - Normal divide (ready at divider count 32, i.e. 33rd RUN cycle): ready at T+34, resp_valid at T+35.
  - Zero divisor: ready combinationally at T+2, resp_valid at T+3.
  - Timeout: resp_valid at T+2+TIMEOUT_CYCLES.
- Back-to-back: next accept no earlier than the IDLE cycle after DONE; minimum initiation interval 36 cycles for normal divides.
- Simultaneous req0/req1 in IDLE: exactly one ready pulse; the loser keeps valid and wins the next IDLE arbitration.

## Structure
- Shared package div_ctrl_pkg: state encoding (2-bit IDLE/START/RUN/DONE), requester-id width, TIMEOUT_CYCLES default, DIV_LATENCY=33 constant for benches.
- Sub-module rr_arbiter_2: combinational two-input round-robin picker (valid[1:0], last_grant → grant, grant_id). The FSM, operand/response registers and timer stay in div_arbiter.

## Test plan
- req0 100/7 after reset → req0_ready at T, resp0_valid at T+35, result 14, exception 0; resp1_valid never asserted.
- req1 −100/7 → resp1_result 0xFFFFFFF2 (−14) at T+35, exception 0.
- req0 5/0 → resp0_valid at T+3, result 0, exception 1.
- req0 and req1 both valid from reset → req0 served first, req1 accepted in the IDLE cycle after req0 DONE; both valid again → req0 granted (alternation).
- Divider model with div_resultRDY stuck 0 → resp_valid at T+42, result 0, exception 1, then IDLE.
- rst=0 during RUN → next cycle IDLE, busy 0, div_rst 1, no resp pulse; after release, a new req0 completes normally.
